// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage register.
// - state_t : occupancy state of a stage; the encoding equals the number of
//             entries held, so the state register drives the occupancy port.
// - OCC_W   : width of the occupancy / state encoding.
// - DATA_W_DEF / CTRL_W_DEF : default bundle widths.
package pipe_pkg;

    localparam int OCC_W      = 2;
    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 8;

    typedef enum logic [OCC_W-1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline stage: a data bundle plus a control bundle.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load            capture d_data/d_ctrl
//   clear           slot becomes invalid: control forced to zero, data zeroed
//                   only when CLR_DATA=1 (otherwise it keeps its last value)
//   d_data, d_ctrl  incoming bundles
//   q_data, q_ctrl  held bundles
// clear has priority over load.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int CTRL_W   = CTRL_W_DEF,
    parameter bit CLR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic [DATA_W-1:0] q_data,
    output logic [CTRL_W-1:0] q_ctrl
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_data <= '0;
            q_ctrl <= '0;
        end else if (clear) begin
            // Control must never leak out of an invalid slot; data is only
            // zeroed on request to avoid needless toggling.
            q_ctrl <= '0;
            if (CLR_DATA) begin
                q_data <= '0;
            end
        end else if (load) begin
            q_data <= d_data;
            q_ctrl <= d_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register carrying a data bundle and a
// control bundle, with per-stage flush and an optional skid slot.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                kill all held entries (and any same-cycle input)
//   in_valid/in_ready    upstream handshake; in_data/in_ctrl upstream bundles
//   out_valid/out_ready  downstream handshake; out_data/out_ctrl from main slot
//   occupancy            entries held (0..1 with SKID=0, 0..2 with SKID=1)
// SKID=0: single slot, in_ready combinational (out_ready | ~out_valid).
// SKID=1: main + skid slot, in_ready registered, breaking the stall path.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int CTRL_W   = CTRL_W_DEF,
    parameter int SKID     = 1,
    parameter bit CLR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [OCC_W-1:0]  occupancy
);

    state_t            state_reg;
    state_t            state_next;
    logic              out_valid_reg;
    logic              in_xfer;
    logic              out_xfer;
    logic              main_load;
    logic              main_clear;
    logic              main_from_skid;
    logic              skid_load;
    logic              skid_clear;
    logic [DATA_W-1:0] main_d_data;
    logic [CTRL_W-1:0] main_d_ctrl;
    logic [DATA_W-1:0] skid_q_data;
    logic [CTRL_W-1:0] skid_q_ctrl;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid_reg & out_ready;

    // Shared occupancy FSM. With SKID=0 the ONE->TWO arc is unreachable
    // because in_ready in ONE implies out_ready, so one FSM serves both modes.
    always_comb begin
        state_next     = state_reg;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            // Flush beats a simultaneous input; an output transfer this
            // cycle has already been sampled downstream.
            state_next = ST_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_next = ST_ONE;
                        main_load  = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end else if (in_xfer && (SKID != 0)) begin
                        state_next = ST_TWO;
                        skid_load  = 1'b1;
                    end else if (out_xfer) begin
                        state_next = ST_EMPTY;
                        main_clear = 1'b1;
                    end
                end
                ST_TWO: begin
                    // The skid entry is younger than main: promote it.
                    if (out_xfer) begin
                        state_next     = ST_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_EMPTY;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= (state_next != ST_EMPTY);
        end
    end

    assign main_d_data = main_from_skid ? skid_q_data : in_data;
    assign main_d_ctrl = main_from_skid ? skid_q_ctrl : in_ctrl;

    pipe_slot #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CLR_DATA (CLR_DATA)
    ) u_main (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (main_load),
        .clear  (main_clear),
        .d_data (main_d_data),
        .d_ctrl (main_d_ctrl),
        .q_data (out_data),
        .q_ctrl (out_ctrl)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_reg;

            // Registered ready: stage can accept unless it will hold two.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    in_ready_reg <= 1'b1;
                end else begin
                    in_ready_reg <= (state_next != ST_TWO);
                end
            end

            assign in_ready = in_ready_reg;

            pipe_slot #(
                .DATA_W   (DATA_W),
                .CTRL_W   (CTRL_W),
                .CLR_DATA (CLR_DATA)
            ) u_skid (
                .clk    (clk),
                .rst_n  (rst_n),
                .load   (skid_load),
                .clear  (skid_clear),
                .d_data (in_data),
                .d_ctrl (in_ctrl),
                .q_data (skid_q_data),
                .q_ctrl (skid_q_ctrl)
            );
        end else begin : g_noskid
            assign in_ready    = out_ready | ~out_valid_reg;
            assign skid_q_data = '0;
            assign skid_q_ctrl = '0;
        end
    endgenerate

    assign out_valid = out_valid_reg;
    assign occupancy = state_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance share stimulus.
// Directed scenarios use constant expectations; the random scenario uses a
// queue model (capacity 2 or 1) of the stage.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_data;
    logic [7:0]  in_ctrl;

    logic        rdy1, ov1, rdy0, ov0;
    logic [31:0] od1, od0;
    logic [7:0]  oc1, oc0;
    logic [1:0]  occ1, occ0;

    int checks = 0;
    int errors = 0;

    logic [39:0] q1[$];
    logic [39:0] q0[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CLR_DATA(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_ctrl(oc1),
        .occupancy(occ1)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(0), .CLR_DATA(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_ctrl(oc0),
        .occupancy(occ0)
    );

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not end, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ov1 !== 1'b0)   begin errors++; $display("FAIL rst_ov1 got %b expected 0", ov1); end
        checks++; if (oc1 !== 8'h00)  begin errors++; $display("FAIL rst_oc1 got %h expected 00", oc1); end
        checks++; if (od1 !== 32'h0)  begin errors++; $display("FAIL rst_od1 got %h expected 0", od1); end
        checks++; if (occ1 !== 2'd0)  begin errors++; $display("FAIL rst_occ1 got %0d expected 0", occ1); end
        checks++; if (rdy1 !== 1'b1)  begin errors++; $display("FAIL rst_rdy1 got %b expected 1", rdy1); end
        checks++; if (ov0 !== 1'b0)   begin errors++; $display("FAIL rst_ov0 got %b expected 0", ov0); end
        checks++; if (rdy0 !== 1'b1)  begin errors++; $display("FAIL rst_rdy0 got %b expected 1", rdy0); end
        // Fill the skid stage, then reset mid-stream between clock edges.
        in_valid = 1'b1; in_data = 32'h11; in_ctrl = 8'h05;
        tick();
        in_data = 32'h22; in_ctrl = 8'h06;
        tick();
        in_valid = 1'b0;
        checks++; if (occ1 !== 2'd2)  begin errors++; $display("FAIL fill_occ1 got %0d expected 2", occ1); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (ov1 !== 1'b0)   begin errors++; $display("FAIL async_ov1 got %b expected 0", ov1); end
        checks++; if (oc1 !== 8'h00)  begin errors++; $display("FAIL async_oc1 got %h expected 00", oc1); end
        checks++; if (occ1 !== 2'd0)  begin errors++; $display("FAIL async_occ1 got %0d expected 0", occ1); end
        checks++; if (rdy1 !== 1'b1)  begin errors++; $display("FAIL async_rdy1 got %b expected 1", rdy1); end
        checks++; if (ov0 !== 1'b0)   begin errors++; $display("FAIL async_ov0 got %b expected 0", ov0); end
        checks++; if (oc0 !== 8'h00)  begin errors++; $display("FAIL async_oc0 got %h expected 00", oc0); end
        tick();
        rst_n = 1'b1;
        tick();
        $display("test_reset: mid-stream reset with occupancy 2 done");
    endtask

    task automatic test_streaming();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_data = 32'(i);
            in_ctrl = 8'(i) | 8'h80;
            tick();
            checks++; if (ov1 !== 1'b1 || od1 !== 32'(i) || oc1 !== (8'(i) | 8'h80))
                begin errors++; $display("FAIL stream1 got v=%b d=%h c=%h expected v=1 d=%h c=%h", ov1, od1, oc1, 32'(i), 8'(i) | 8'h80); end
            checks++; if (ov0 !== 1'b1 || od0 !== 32'(i) || oc0 !== (8'(i) | 8'h80))
                begin errors++; $display("FAIL stream0 got v=%b d=%h c=%h expected v=1 d=%h c=%h", ov0, od0, oc0, 32'(i), 8'(i) | 8'h80); end
            $display("stream: sent %h, out1=%h out0=%h", i, od1, od0);
        end
        // Bubble: no new input, output consumed.
        in_valid = 1'b0;
        tick();
        checks++; if (ov1 !== 1'b0 || oc1 !== 8'h00) begin errors++; $display("FAIL bubble1 got v=%b c=%h expected v=0 c=00", ov1, oc1); end
        checks++; if (ov0 !== 1'b0 || oc0 !== 8'h00) begin errors++; $display("FAIL bubble0 got v=%b c=%h expected v=0 c=00", ov0, oc0); end
        checks++; if (occ0 !== 2'd0) begin errors++; $display("FAIL bubble_occ0 got %0d expected 0", occ0); end
        $display("stream: bubble after 16 entries");
    endtask

    task automatic test_stall();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA; in_ctrl = 8'h1A;
        tick();
        in_data = 32'hB; in_ctrl = 8'h1B;
        tick();
        in_data = 32'hC; in_ctrl = 8'h1C;
        checks++; if (occ1 !== 2'd2 || rdy1 !== 1'b0) begin errors++; $display("FAIL stall_full got occ=%0d rdy=%b expected occ=2 rdy=0", occ1, rdy1); end
        tick();
        checks++; if (occ1 !== 2'd2 || od1 !== 32'hA) begin errors++; $display("FAIL stall_hold got occ=%0d d=%h expected occ=2 d=a", occ1, od1); end
        out_ready = 1'b1;
        tick();
        checks++; if (ov1 !== 1'b1 || od1 !== 32'hB || oc1 !== 8'h1B || occ1 !== 2'd1)
            begin errors++; $display("FAIL stall_rel_b got v=%b d=%h c=%h occ=%0d expected v=1 d=b c=1b occ=1", ov1, od1, oc1, occ1); end
        checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL stall_rdy got %b expected 1", rdy1); end
        tick();
        in_valid = 1'b0;
        checks++; if (ov1 !== 1'b1 || od1 !== 32'hC || oc1 !== 8'h1C)
            begin errors++; $display("FAIL stall_rel_c got v=%b d=%h c=%h expected v=1 d=c c=1c", ov1, od1, oc1); end
        tick();
        checks++; if (ov1 !== 1'b0 || occ1 !== 2'd0) begin errors++; $display("FAIL stall_drain got v=%b occ=%0d expected v=0 occ=0", ov1, occ1); end
        $display("stall: A,B held then released in order, C delivered");
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA; in_ctrl = 8'h2A;
        tick();
        in_data = 32'hB; in_ctrl = 8'h2B;
        tick();
        flush = 1'b1; in_data = 32'hDEAD; in_ctrl = 8'hFF;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (ov1 !== 1'b0 || oc1 !== 8'h00 || occ1 !== 2'd0 || rdy1 !== 1'b1)
            begin errors++; $display("FAIL flush_two got v=%b c=%h occ=%0d rdy=%b expected v=0 c=00 occ=0 rdy=1", ov1, oc1, occ1, rdy1); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (ov1 !== 1'b0 || od1 === 32'hDEAD) begin errors++; $display("FAIL flush_leak got v=%b d=%h expected v=0", ov1, od1); end
        end
        // Flush while both stages hold one entry and are ready to accept.
        in_valid = 1'b1; in_data = 32'h55; in_ctrl = 8'h55;
        tick();
        flush = 1'b1; in_data = 32'hDEAD; in_ctrl = 8'hFF;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (ov1 !== 1'b0 || oc1 !== 8'h00) begin errors++; $display("FAIL flush_one1 got v=%b c=%h expected v=0 c=00", ov1, oc1); end
        checks++; if (ov0 !== 1'b0 || oc0 !== 8'h00) begin errors++; $display("FAIL flush_one0 got v=%b c=%h expected v=0 c=00", ov0, oc0); end
        tick();
        checks++; if (ov1 !== 1'b0 || ov0 !== 1'b0) begin errors++; $display("FAIL flush_after got v1=%b v0=%b expected 0 0", ov1, ov0); end
        $display("flush: 0xDEAD discarded in TWO and ONE states");
    endtask

    task automatic test_random();
        int n_in1 = 0, n_out1 = 0, n_in0 = 0, n_out0 = 0;
        logic acc1, acc0, pop1, pop0;
        do_reset();
        q1.delete();
        q0.delete();
        for (int c = 0; c < 10000; c++) begin
            flush     = ($urandom_range(0, 99) == 0);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) < ((((c / 500) % 2) != 0) ? 1 : 3));
            in_data   = $urandom;
            in_ctrl   = 8'($urandom);
            #1;
            checks++; if (rdy1 !== (q1.size() < 2)) begin errors++; $display("FAIL rnd_rdy1 c=%0d got %b expected %b", c, rdy1, q1.size() < 2); end
            checks++; if (ov1 !== (q1.size() > 0)) begin errors++; $display("FAIL rnd_ov1 c=%0d got %b expected %b", c, ov1, q1.size() > 0); end
            checks++; if (occ1 !== 2'(q1.size())) begin errors++; $display("FAIL rnd_occ1 c=%0d got %0d expected %0d", c, occ1, q1.size()); end
            checks++; if (oc1 !== ((q1.size() > 0) ? q1[0][7:0] : 8'h00)) begin errors++; $display("FAIL rnd_oc1 c=%0d got %h", c, oc1); end
            if (q1.size() > 0) begin
                checks++; if (od1 !== q1[0][39:8]) begin errors++; $display("FAIL rnd_od1 c=%0d got %h expected %h", c, od1, q1[0][39:8]); end
            end
            checks++; if (rdy0 !== ((q0.size() == 0) || out_ready)) begin errors++; $display("FAIL rnd_rdy0 c=%0d got %b", c, rdy0); end
            checks++; if (ov0 !== (q0.size() > 0)) begin errors++; $display("FAIL rnd_ov0 c=%0d got %b expected %b", c, ov0, q0.size() > 0); end
            checks++; if (occ0 !== 2'(q0.size())) begin errors++; $display("FAIL rnd_occ0 c=%0d got %0d expected %0d", c, occ0, q0.size()); end
            checks++; if (oc0 !== ((q0.size() > 0) ? q0[0][7:0] : 8'h00)) begin errors++; $display("FAIL rnd_oc0 c=%0d got %h", c, oc0); end
            if (q0.size() > 0) begin
                checks++; if (od0 !== q0[0][39:8]) begin errors++; $display("FAIL rnd_od0 c=%0d got %h expected %h", c, od0, q0[0][39:8]); end
            end
            acc1 = in_valid && (q1.size() < 2);
            pop1 = out_ready && (q1.size() > 0);
            acc0 = in_valid && ((q0.size() == 0) || out_ready);
            pop0 = out_ready && (q0.size() > 0);
            @(posedge clk);
            if (pop1) n_out1++;
            if (pop0) n_out0++;
            if (flush) begin
                q1.delete();
                q0.delete();
            end else begin
                if (pop1) void'(q1.pop_front());
                if (acc1) begin q1.push_back({in_data, in_ctrl}); n_in1++; end
                if (pop0) void'(q0.pop_front());
                if (acc0) begin q0.push_back({in_data, in_ctrl}); n_in0++; end
            end
            #1;
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        $display("random: skid in=%0d out=%0d, noskid in=%0d out=%0d", n_in1, n_out1, n_in0, n_out0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0;
        test_reset();
        test_streaming();
        test_stall();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
